multu_param: RTL and testbench

- Parametrised successor to the 32-bit sequential unsigned multiplier.
- Shift-add, one multiplier bit per clock; produces the full 2*WIDTH-bit product as hi/lo halves.
- Adds a per-operation signed/unsigned mode, a busy flag and a one-cycle done pulse.
- Sits beside the adder/ALU as the multi-cycle multiply unit feeding the HI/LO result registers.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_cneg.sv | 13 +
 rtl/multu_param.sv | 132 +++++++++++++
 tb/tb_multu_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiply unit:
// controller state encoding and the default operand width.
package mult_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

endpackage

// File: rtl/mult_cneg.sv
// Conditional two's-complement negator: passes the input through,
// or returns its negation when en is set.
module mult_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_v,
  input  logic         en,
  output logic [W-1:0] out_v
);

  assign out_v = en ? (~in_v + W'(1)) : in_v;

endmodule

// File: rtl/multu_param.sv
// Shift-add multiplier, one multiplier bit per clock, with a
// signed mode: operands become magnitudes and the sign is fixed up last.
module multu_param
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  input  logic             doMult,
  output logic             busy,
  output logic             mult_done,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH-1:0] prod_fix;

  mult_cneg #(.W(WIDTH)) u_neg_a (
    .in_v  (a),
    .en    (is_signed & a[WIDTH-1]),
    .out_v (a_mag)
  );

  mult_cneg #(.W(WIDTH)) u_neg_b (
    .in_v  (b),
    .en    (is_signed & b[WIDTH-1]),
    .out_v (b_mag)
  );

  mult_cneg #(.W(2*WIDTH)) u_neg_p (
    .in_v  ({acc_q, mplier_q}),
    .en    (neg_q),
    .out_v (prod_fix)
  );

  // Carry lands in acc_sum[WIDTH] and is shifted back into the accumulator.
  always_comb begin
    acc_sum = {1'b0, acc_q}
            + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      IDLE: begin
        if (doMult) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum[WIDTH:1];
        mplier_d = {acc_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        {hi_d, lo_d} = prod_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign mult_done = done_q;
  assign out_hi    = hi_q;
  assign out_lo    = lo_q;

endmodule

// File: tb/tb_multu_param.sv
// Scoreboard bench for multu_param: 32-bit directed vectors and
// an 8-bit instance checked against a behavioural product.
module tb_multu_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a32 = '0, b32 = '0;
  logic        s32 = 1'b0, go32 = 1'b0;
  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        s8 = 1'b0, go8 = 1'b0;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multu_param #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .a(a32), .b(b32),
    .is_signed(s32), .doMult(go32), .busy(busy32),
    .mult_done(done32), .out_hi(hi32), .out_lo(lo32)
  );

  multu_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8),
    .is_signed(s8), .doMult(go8), .busy(busy8),
    .mult_done(done8), .out_hi(hi8), .out_lo(lo8)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitors: pop and compare whenever a DUT pulses mult_done.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        n_total++;
        $display("FAIL w32 unexpected done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("w32 product", {hi32, lo32}, e.prod);
        chk("w32 latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        n_total++;
        $display("FAIL w8 unexpected done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8 product", 64'({hi8, lo8}), e.prod);
        chk("w8 latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge: operation is accepted on the next posedge.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [63:0] prod);
    exp_t e;
    a32 = a; b32 = b; s32 = s; go32 = 1'b1;
    e.prod = prod;
    e.due  = cyc + 1 + 33;
    q32.push_back(e);
  endtask

  task automatic wait_idle32();
    int n = 0;
    while (busy32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy32) begin
      n_total++;
      $display("FAIL w32 idle timeout busy=%b want 0", busy32);
    end
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [63:0] prod);
    issue32(a, b, s, prod);
    @(negedge clk);
    go32 = 1'b0;
    chk("w32 busy after start", 64'(busy32), 64'd1);
    wait_idle32();
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic s);
    exp_t e;
    logic [15:0] p;
    int n = 0;
    if (s) p = 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
    else   p = {8'd0, a} * {8'd0, b};
    a8 = a; b8 = b; s8 = s; go8 = 1'b1;
    e.prod = 64'(p);
    e.due  = cyc + 1 + 9;
    q8.push_back(e);
    @(negedge clk);
    go8 = 1'b0;
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy8) begin
      n_total++;
      $display("FAIL w8 idle timeout busy=%b want 0", busy8);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset done", 64'(done32), 64'd0);
    chk("reset out", {hi32, lo32}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run32(32'd2, 32'd5, 1'b0, 64'd10);
    run32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run32(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
    run32(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    run32(32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000);
    run32(32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000);
    run32(32'd0, 32'hFFFFFFFB, 1'b1, 64'd0);

    // Reset ten cycles into a run aborts it without a done pulse.
    issue32(32'd11, 32'd13, 1'b0, 64'd143);
    @(negedge clk);
    go32 = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    void'(q32.pop_back());
    @(negedge clk);
    chk("abort busy", 64'(busy32), 64'd0);
    chk("abort out", {hi32, lo32}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort no done", 64'(done32), 64'd0);

    // New request mid-run must be ignored.
    issue32(32'd7, 32'd9, 1'b0, 64'd63);
    @(negedge clk);
    go32 = 1'b0;
    repeat (5) @(negedge clk);
    a32 = 32'd100; b32 = 32'd100; go32 = 1'b1;
    @(negedge clk);
    go32 = 1'b0;
    wait_idle32();
    @(negedge clk);
    chk("ignored start idle", 64'(busy32), 64'd0);

    // Request during the done cycle starts a second operation.
    issue32(32'd3, 32'd4, 1'b0, 64'd12);
    @(negedge clk);
    go32 = 1'b0;
    begin
      int n = 0;
      while (!done32 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    chk("b2b first done", 64'(done32), 64'd1);
    issue32(32'd6, 32'd7, 1'b0, 64'd42);
    @(negedge clk);
    go32 = 1'b0;
    chk("b2b busy", 64'(busy32), 64'd1);
    chk("b2b done drops", 64'(done32), 64'd0);
    wait_idle32();
    @(negedge clk);

    run8(8'h80, 8'h80, 1'b1);
    run8(8'hFF, 8'hFF, 1'b0);
    run8(8'hFF, 8'h01, 1'b1);
    for (int i = 0; i < 1000; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3) @(negedge clk);

    chk("w32 queue drained", 64'(q32.size()), 64'd0);
    chk("w8 queue drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
